// File: rtl/sys_bus_regs_pkg.sv
// sys_bus_regs_pkg: shared types, register map offsets and helpers for the
// sys_bus_regs responder.
package sys_bus_regs_pkg;

  typedef logic [31:0] reg32_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WACK = 2'd1,
    RD   = 2'd2
  } sys_bus_regs_state_t;

  // Byte offsets inside the decoded slot.
  localparam reg32_t OFS_ID         = 32'h0000_0000;
  localparam reg32_t OFS_CTRL       = 32'h0000_0004;
  localparam reg32_t OFS_IRQ_STATUS = 32'h0000_0008;
  localparam reg32_t OFS_IRQ_MASK   = 32'h0000_000C;
  localparam reg32_t OFS_STATUS     = 32'h0000_0010;
  localparam reg32_t OFS_REG_BASE   = 32'h0000_0020;

  // Mask with the low 'ni' bits set; used to keep unimplemented IRQ bits at 0.
  function automatic reg32_t ni_mask(input int ni);
    reg32_t m;
    m = 32'h0000_0000;
    for (int i = 0; i < 32; i++) begin
      m[i] = (i < ni);
    end
    return m;
  endfunction

  // Mask selecting the decoded word-address bits [aw-1:2] of a byte address.
  function automatic reg32_t word_addr_mask(input int aw);
    reg32_t m;
    m = 32'h0000_0000;
    for (int i = 2; i < 32; i++) begin
      m[i] = (i < aw);
    end
    return m;
  endfunction

endpackage

// File: rtl/sys_bus_regs_if.sv
// sys_bus_if: single-slot system bus connection between the interconnect
// (master side) and a register responder (slave side).
interface sys_bus_if;
  import sys_bus_regs_pkg::*;

  reg32_t addr;
  reg32_t wdata;
  logic   wen;
  logic   ren;
  reg32_t rdata;
  logic   err;
  logic   ack;

  modport m (output addr, wdata, wen, ren, input rdata, err, ack);
  modport s (input addr, wdata, wen, ren, output rdata, err, ack);

endinterface

// File: rtl/sys_bus_regs_rdpipe.sv
// sys_bus_regs_rdpipe: read latency pipe. Captures read data/err in the
// request cycle and presents them together with ack exactly RL clocks later.
// rdata holds its last value outside ack cycles; err is only high with ack.
module sys_bus_regs_rdpipe
  import sys_bus_regs_pkg::*;
#(
  parameter int RL = 1
) (
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   start,
  input  logic   active,
  input  reg32_t data,
  input  logic   err_in,
  output logic   ack,
  output reg32_t rdata,
  output logic   err
);

  localparam logic [1:0] CNT_INIT = 2'(RL - 1);
  localparam logic       FAST     = (RL == 1);

  logic [1:0] cnt_r;
  reg32_t     cap_data_r;
  logic       cap_err_r;
  logic       ack_r;
  reg32_t     rdata_r;
  logic       err_r;
  logic       fire_now_s;
  logic       fire_late_s;

  // Decide whether the ack cycle starts on the coming edge.
  always_comb begin
    fire_now_s  = 1'b0;
    fire_late_s = 1'b0;
    if (start) begin
      fire_now_s = FAST;
    end else begin
      fire_late_s = active && (cnt_r == 2'd1);
    end
  end

  // Latency counter, capture registers and registered ack/rdata/err.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_r      <= 2'd0;
      cap_data_r <= 32'h0000_0000;
      cap_err_r  <= 1'b0;
      ack_r      <= 1'b0;
      rdata_r    <= 32'h0000_0000;
      err_r      <= 1'b0;
    end else begin
      if (start) begin
        cnt_r      <= CNT_INIT;
        cap_data_r <= data;
        cap_err_r  <= err_in;
      end else if (active && (cnt_r != 2'd0)) begin
        cnt_r <= cnt_r - 2'd1;
      end else begin
        cnt_r <= cnt_r;
      end
      ack_r <= fire_now_s | fire_late_s;
      if (fire_now_s) begin
        rdata_r <= data;
        err_r   <= err_in;
      end else if (fire_late_s) begin
        rdata_r <= cap_data_r;
        err_r   <= cap_err_r;
      end else begin
        err_r   <= 1'b0;
      end
    end
  end

  assign ack   = ack_r;
  assign rdata = rdata_r;
  assign err   = err_r;

endmodule

// File: rtl/sys_bus_regs.sv
// sys_bus_regs: generic sys_bus slave responder with ID, CTRL, IRQ status /
// mask, STATUS and NR general-purpose registers.
// Optional feature: define SYS_BUS_REGS_LOCK_EN to make CTRL[31] a sticky
// lock bit that refuses writes to REG[k] and IRQ_MASK with err.
module sys_bus_regs
  import sys_bus_regs_pkg::*;
#(
  parameter int     AW = 20,
  parameter int     NR = 8,
  parameter int     RL = 1,
  parameter int     NI = 16,
  parameter reg32_t ID = 32'h5253_0001
) (
  input  logic                clk_i,
  input  logic                rst_i,
  sys_bus_if.s                bus,
  output reg32_t              ctrl_o,
  output logic [NR-1:0][31:0] reg_o,
  input  logic [NI-1:0]       irq_event_i,
  output logic                irq_o
);

  localparam reg32_t NI_MASK   = ni_mask(NI);
  localparam reg32_t ADDR_USED = word_addr_mask(AW);

  sys_bus_regs_state_t state_r;
  sys_bus_regs_state_t next_state_s;

  reg32_t              ctrl_r;
  reg32_t              irq_status_r;
  reg32_t              irq_mask_r;
  logic                overrun_r;
  logic                irq_r;
  logic                wr_err_r;
  logic [NR-1:0][31:0] regs_r;

  reg32_t              byte_ofs_s;
  logic                hit_id_s;
  logic                hit_ctrl_s;
  logic                hit_irq_status_s;
  logic                hit_mask_s;
  logic                hit_status_s;
  logic [NR-1:0]       reg_sel_s;
  logic                is_reg_s;
  logic                unmapped_s;
  reg32_t              reg_rd_s;
  reg32_t              rd_data_s;
  logic                busy_s;
  logic                lock_s;
  reg32_t              ctrl_wr_s;
  logic                wr_err_s;
  logic                wr_go_s;
  logic                rd_go_s;
  logic                overrun_evt_s;
  reg32_t              w1c_s;
  reg32_t              irq_status_next_s;
  logic                rd_ack_s;
  reg32_t              rd_rdata_s;
  logic                rd_err_s;
  logic                unused_addr_s;

  // Address bits outside [AW-1:2] are deliberately ignored.
  assign unused_addr_s = ^(bus.addr & ~ADDR_USED);

  // Address decode: word-aligned offset within the slot and per-register hits.
  always_comb begin
    byte_ofs_s       = bus.addr & ADDR_USED;
    hit_id_s         = (byte_ofs_s == OFS_ID);
    hit_ctrl_s       = (byte_ofs_s == OFS_CTRL);
    hit_irq_status_s = (byte_ofs_s == OFS_IRQ_STATUS);
    hit_mask_s       = (byte_ofs_s == OFS_IRQ_MASK);
    hit_status_s     = (byte_ofs_s == OFS_STATUS);
    for (int k = 0; k < NR; k++) begin
      reg_sel_s[k] = (byte_ofs_s == (OFS_REG_BASE + 32'(k * 4)));
    end
    is_reg_s   = |reg_sel_s;
    unmapped_s = !(hit_id_s || hit_ctrl_s || hit_irq_status_s ||
                   hit_mask_s || hit_status_s || is_reg_s);
  end

  // Read data mux, sampled in the request cycle; unmapped offsets read 0.
  always_comb begin
    busy_s   = (state_r != IDLE);
    reg_rd_s = 32'h0000_0000;
    for (int k = 0; k < NR; k++) begin
      reg_rd_s = reg_rd_s | ({32{reg_sel_s[k]}} & regs_r[k]);
    end
    rd_data_s = 32'h0000_0000;
    if (hit_id_s) begin
      rd_data_s = ID;
    end else if (hit_ctrl_s) begin
      rd_data_s = ctrl_r;
    end else if (hit_irq_status_s) begin
      rd_data_s = irq_status_r;
    end else if (hit_mask_s) begin
      rd_data_s = irq_mask_r;
    end else if (hit_status_s) begin
      rd_data_s = {30'd0, overrun_r, busy_s};
    end else if (is_reg_s) begin
      rd_data_s = reg_rd_s;
    end else begin
      rd_data_s = 32'h0000_0000;
    end
  end

  // Write qualification: lock handling, error classification, accept/drop.
  always_comb begin
`ifdef SYS_BUS_REGS_LOCK_EN
    lock_s    = ctrl_r[31];
    ctrl_wr_s = bus.wdata | {ctrl_r[31], 31'd0};
`else
    lock_s    = 1'b0;
    ctrl_wr_s = bus.wdata;
`endif
    wr_err_s      = unmapped_s || (lock_s && (hit_mask_s || is_reg_s));
    wr_go_s       = (state_r == IDLE) && bus.wen;
    rd_go_s       = (state_r == IDLE) && bus.ren && !bus.wen;
    overrun_evt_s = (state_r != IDLE) && (bus.wen || bus.ren);
    if (wr_go_s && hit_irq_status_s) begin
      w1c_s = bus.wdata;
    end else begin
      w1c_s = 32'h0000_0000;
    end
    // A new event wins over a clear of the same bit in the same cycle.
    irq_status_next_s = ((irq_status_r & ~w1c_s) | 32'(irq_event_i)) & NI_MASK;
  end

  // FSM state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next state: a write wins over a simultaneous read.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.wen) begin
          next_state_s = WACK;
        end else if (bus.ren) begin
          next_state_s = RD;
        end else begin
          next_state_s = IDLE;
        end
      end
      WACK: begin
        next_state_s = IDLE;
      end
      RD: begin
        if (rd_ack_s) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = RD;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // Register state; an accepted write lands on the edge that raises ack.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ctrl_r       <= 32'h0000_0000;
      irq_status_r <= 32'h0000_0000;
      irq_mask_r   <= 32'h0000_0000;
      overrun_r    <= 1'b0;
      irq_r        <= 1'b0;
      wr_err_r     <= 1'b0;
      regs_r       <= '0;
    end else begin
      irq_status_r <= irq_status_next_s;
      irq_r        <= |(irq_status_r & irq_mask_r);
      if (overrun_evt_s) begin
        overrun_r <= 1'b1;
      end else if (wr_go_s && hit_status_s) begin
        overrun_r <= 1'b0;
      end else begin
        overrun_r <= overrun_r;
      end
      if (wr_go_s) begin
        wr_err_r <= wr_err_s;
      end else begin
        wr_err_r <= wr_err_r;
      end
      if (wr_go_s && !wr_err_s) begin
        if (hit_ctrl_s) begin
          ctrl_r <= ctrl_wr_s;
        end else begin
          ctrl_r <= ctrl_r;
        end
        if (hit_mask_s) begin
          irq_mask_r <= bus.wdata & NI_MASK;
        end else begin
          irq_mask_r <= irq_mask_r;
        end
        for (int k = 0; k < NR; k++) begin
          if (reg_sel_s[k]) begin
            regs_r[k] <= bus.wdata;
          end
        end
      end
    end
  end

  sys_bus_regs_rdpipe #(
    .RL (RL)
  ) u_rdpipe (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .start  (rd_go_s),
    .active (state_r == RD),
    .data   (rd_data_s),
    .err_in (unmapped_s),
    .ack    (rd_ack_s),
    .rdata  (rd_rdata_s),
    .err    (rd_err_s)
  );

  assign bus.ack   = (state_r == WACK) | rd_ack_s;
  assign bus.err   = ((state_r == WACK) & wr_err_r) | rd_err_s;
  assign bus.rdata = rd_rdata_s;
  assign ctrl_o    = ctrl_r;
  assign reg_o     = regs_r;
  assign irq_o     = irq_r;

endmodule

// File: tb/tb_sys_bus_regs.sv
// tb_sys_bus_regs: directed plus randomized bench for sys_bus_regs against
// a register-map level reference model.
module tb_sys_bus_regs;
  import sys_bus_regs_pkg::*;

  localparam int          AW = 20;
  localparam int          NR = 8;
  localparam int          RL = 3;
  localparam int          NI = 16;
  localparam logic [31:0] ID = 32'h5253_0001;
  localparam logic [31:0] NI_MSK = 32'((64'd1 << NI) - 64'd1);
  localparam logic [31:0] AW_MSK = 32'((64'd1 << AW) - 64'd1);
`ifdef SYS_BUS_REGS_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sys_bus_if bus();
  logic [31:0]          ctrl;
  logic [NR-1:0][31:0]  regs;
  logic [NI-1:0]        irq_ev;
  logic                 irq;

  sys_bus_regs #(.AW(AW), .NR(NR), .RL(RL), .NI(NI), .ID(ID)) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus.s), .ctrl_o(ctrl), .reg_o(regs),
    .irq_event_i(irq_ev), .irq_o(irq)
  );

  int tests = 0;
  int fails = 0;

  // reference model of the architectural registers
  logic [31:0] m_ctrl, m_irq, m_mask;
  logic        m_ovr;
  logic [31:0] m_regs [NR];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  function automatic void m_reset();
    m_ctrl = 0; m_irq = 0; m_mask = 0; m_ovr = 0;
    for (int k = 0; k < NR; k++) m_regs[k] = 0;
  endfunction

  function automatic int unsigned m_ofs(input logic [31:0] a);
    int unsigned o;
    o = 32'(a & AW_MSK);
    return o - (o % 4);
  endfunction

  task automatic m_read(input logic [31:0] a, output logic [31:0] d, output logic e);
    int unsigned o;
    o = m_ofs(a);
    e = 1'b0;
    if (o == 0) d = ID;
    else if (o == 4) d = m_ctrl;
    else if (o == 8) d = m_irq;
    else if (o == 12) d = m_mask;
    else if (o == 16) d = {30'd0, m_ovr, 1'b0};
    else if (o >= 32 && o < 32 + 4 * NR) d = m_regs[(o - 32) / 4];
    else begin d = 0; e = 1'b1; end
  endtask

  // applies a write to the model, returns the expected err
  function automatic logic m_write(input logic [31:0] a, input logic [31:0] d);
    int unsigned o;
    logic locked;
    o = m_ofs(a);
    locked = LOCK && m_ctrl[31];
    if (o == 0) return 1'b0;
    if (o == 4) begin
      m_ctrl = LOCK ? (d | (m_ctrl & 32'h8000_0000)) : d;
      return 1'b0;
    end
    if (o == 8) begin m_irq = m_irq & ~d; return 1'b0; end
    if (o == 12) begin
      if (locked) return 1'b1;
      m_mask = d & NI_MSK;
      return 1'b0;
    end
    if (o == 16) begin m_ovr = 1'b0; return 1'b0; end
    if (o >= 32 && o < 32 + 4 * NR) begin
      if (locked) return 1'b1;
      m_regs[(o - 32) / 4] = d;
      return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic chk_state(input string tag);
    chk({tag, "_ctrl"}, ctrl, m_ctrl);
    for (int k = 0; k < NR; k++) chk({tag, "_reg"}, regs[k], m_regs[k]);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                          input logic [NI-1:0] ev, input string tag);
    logic e;
    e = m_write(a, d);
    m_irq = (m_irq | 32'(ev)) & NI_MSK;
    bus.addr = a; bus.wdata = d; bus.wen = 1'b1; irq_ev = ev;
    @(posedge clk); #1;
    bus.wen = 1'b0; irq_ev = '0;
    chk({tag, "_wack"}, 32'(bus.ack), 32'd1);
    chk({tag, "_werr"}, 32'(bus.err), 32'(e));
    chk_state(tag);
    @(posedge clk); #1;
    chk({tag, "_wack_end"}, 32'(bus.ack), 32'd0);
  endtask

  task automatic do_read(input logic [31:0] a, input string tag);
    logic [31:0] d;
    logic e;
    m_read(a, d, e);
    bus.addr = a; bus.ren = 1'b1;
    @(posedge clk); #1;
    bus.ren = 1'b0;
    for (int c = 1; c < RL; c++) begin
      chk({tag, "_early_ack"}, 32'(bus.ack), 32'd0);
      @(posedge clk); #1;
    end
    chk({tag, "_rack"}, 32'(bus.ack), 32'd1);
    chk({tag, "_rdata"}, bus.rdata, d);
    chk({tag, "_rerr"}, 32'(bus.err), 32'(e));
    @(posedge clk); #1;
    chk({tag, "_rack_end"}, 32'(bus.ack), 32'd0);
    chk({tag, "_rdata_hold"}, bus.rdata, d);
  endtask

  logic [31:0] a, d, ed;
  logic        e, ee;
  int          acks;
  int unsigned o;

  initial begin
    rst = 1'b1;
    bus.addr = 0; bus.wdata = 0; bus.wen = 1'b0; bus.ren = 1'b0;
    irq_ev = '0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack", 32'(bus.ack), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_rdata", bus.rdata, 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk_state("rst");
    rst = 1'b0;
    @(posedge clk); #1;

    // ID read with RL-cycle latency
    do_read(32'h0000_0000, "id");

    // REG[0] write then readback
    do_write(32'h0000_0020, 32'hDEAD_BEEF, '0, "reg0_w");
    do_read(32'h0000_0020, "reg0_r");

    // interrupt set, mask, registered irq_o
    do_write(32'h0000_000C, 32'h0000_0008, '0, "mask_w");
    irq_ev = 16'h0008;
    @(posedge clk); #1;
    irq_ev = '0;
    m_irq = m_irq | 32'h8;
    chk("irq_not_yet", 32'(irq), 32'd0);
    @(posedge clk); #1;
    chk("irq_rise", 32'(irq), 32'd1);
    do_read(32'h0000_0008, "irqst_r1");

    // W1C colliding with a new event: set wins
    do_write(32'h0000_0008, 32'h0000_0008, 16'h0008, "w1c_coll");
    chk("irq_hold", 32'(irq), 32'd1);
    do_read(32'h0000_0008, "irqst_r2");
    do_write(32'h0000_0008, 32'h0000_0008, '0, "w1c_clean");
    chk("irq_fall", 32'(irq), 32'd0);
    do_read(32'h0000_0008, "irqst_r3");

    // unmapped accesses
    do_read(32'h0000_01F0, "unmap_r");
    do_write(32'h0000_0014, 32'h1111_2222, '0, "unmap_w");

    // requests while busy are dropped and flag overrun
    m_read(32'h0000_0000, ed, ee);
    bus.addr = 32'h0000_0000; bus.ren = 1'b1;
    @(posedge clk); #1;
    acks = 0;
    for (int c = 1; c <= RL + 3; c++) begin
      if (bus.ack === 1'b1) begin
        acks++;
        chk("ovr_rdata", bus.rdata, ed);
      end
      bus.ren = (c == 1);
      bus.addr = (c == 1) ? 32'h0000_0004 : 32'h0000_0020;
      bus.wen = (c == 2);
      bus.wdata = 32'h1234_5678;
      @(posedge clk); #1;
    end
    m_ovr = 1'b1;
    chk("ovr_ack_count", 32'(acks), 32'd1);
    chk_state("ovr");
    do_read(32'h0000_0010, "status_ovr");
    do_write(32'h0000_0010, 32'h0000_0000, '0, "status_clr");
    do_read(32'h0000_0010, "status_clr_r");

    // simultaneous wen and ren: only the write, one ack
    e = m_write(32'h0000_0024, 32'h0BAD_F00D);
    bus.addr = 32'h0000_0024; bus.wdata = 32'h0BAD_F00D; bus.wen = 1'b1; bus.ren = 1'b1;
    @(posedge clk); #1;
    bus.wen = 1'b0; bus.ren = 1'b0;
    acks = 0;
    for (int c = 1; c <= RL + 2; c++) begin
      if (bus.ack === 1'b1) begin
        acks++;
        chk("wr_rd_err", 32'(bus.err), 32'(e));
      end
      @(posedge clk); #1;
    end
    chk("wr_rd_ack_count", 32'(acks), 32'd1);
    chk_state("wr_rd");
    do_read(32'h0000_0024, "wr_rd_r");

    // randomized accesses, high and low address bits scrambled
    for (int i = 0; i < 48; i++) begin
      case ($urandom_range(0, 9))
        0: o = 32'h00;
        1: o = 32'h04;
        2: o = 32'h08;
        3: o = 32'h0C;
        4: o = 32'h10;
        5: o = 32'h14;
        6, 7: o = 32'h20 + 4 * $urandom_range(0, NR - 1);
        8: o = 32'h20 + 4 * NR;
        default: o = 32'h1FC;
      endcase
      a = ($urandom & ~AW_MSK) | o | 32'($urandom_range(0, 3));
      d = $urandom;
      if ($urandom_range(0, 1) == 1) do_write(a, d, '0, "rnd_w");
      else do_read(a, "rnd_r");
    end

`ifdef SYS_BUS_REGS_LOCK_EN
    // lock: REG/IRQ_MASK writes refused, lock bit sticky
    do_write(32'h0000_0004, 32'h8000_0000, '0, "lock_set");
    do_write(32'h0000_0024, 32'hCAFE_0001, '0, "lock_reg");
    do_write(32'h0000_000C, 32'h0000_FFFF, '0, "lock_mask");
    do_write(32'h0000_0004, 32'h0000_0000, '0, "lock_keep");
    do_read(32'h0000_0004, "lock_ctrl_r");
`endif

    // reset in the middle of a read: no ack ever appears
    bus.addr = 32'h0000_0004; bus.ren = 1'b1;
    @(posedge clk); #1;
    bus.ren = 1'b0;
    rst = 1'b1;
    #1;
    m_reset();
    chk("mid_rst_ack", 32'(bus.ack), 32'd0);
    chk("mid_rst_rdata", bus.rdata, 32'd0);
    chk("mid_rst_err", 32'(bus.err), 32'd0);
    chk("mid_rst_irq", 32'(irq), 32'd0);
    chk_state("mid_rst");
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < RL + 2; c++) begin
      chk("post_rst_no_ack", 32'(bus.ack), 32'd0);
      @(posedge clk); #1;
    end
    do_read(32'h0000_0004, "post_rst_ctrl");
    do_read(32'h0000_0020, "post_rst_reg0");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
